// File: rtl/rresp_assembler.sv
// Read-response assembler: gathers a burst of read beats into one line.
// Lanes fill from a start lane with wrap; errors and length mismatches flag the line.
module rresp_assembler #(
  parameter  int LANE_W = 16,
  parameter  int LANES  = 16,
  localparam int IDX_W  = $clog2(LANES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [IDX_W-1:0]        cmd_lane,
  input  logic [IDX_W-1:0]        cmd_len,
  input  logic                    cmd_merge,
  input  logic                    r_valid,
  output logic                    r_ready,
  input  logic [LANE_W-1:0]       r_data,
  input  logic [1:0]              r_resp,
  input  logic                    r_last,
  output logic                    line_valid,
  input  logic                    line_ready,
  output logic [LANES*LANE_W-1:0] line_data,
  output logic [LANES-1:0]        line_mask,
  output logic                    line_err
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   remaining;

  logic cmd_fire;
  logic beat_fire;
  logic rem_zero;
  logic burst_end;
  logic beat_err;

  assign cmd_ready  = (state == IDLE);
  assign r_ready    = (state == COLLECT);
  assign line_valid = (state == DONE);

  assign cmd_fire  = cmd_valid & cmd_ready;
  assign beat_fire = r_valid & r_ready;
  assign rem_zero  = (remaining == '0);
  assign burst_end = rem_zero | r_last;

  // Bad response, early last, or missing last all poison the line.
  assign beat_err = (r_resp != 2'b00)
                  | (r_last & ~rem_zero)
                  | (rem_zero & ~r_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (cmd_valid) state_nx = COLLECT;
      end
      COLLECT: begin
        if (r_valid && burst_end) state_nx = DONE;
      end
      DONE: begin
        if (line_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Line contents persist past the line handshake so merge can build on them.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      remaining <= '0;
      line_data <= '0;
      line_mask <= '0;
      line_err  <= 1'b0;
    end else if (cmd_fire) begin
      ptr       <= cmd_lane;
      remaining <= cmd_len;
      line_mask <= '0;
      line_err  <= 1'b0;
      if (!cmd_merge) line_data <= '0;
    end else if (beat_fire) begin
      line_data[int'(ptr)*LANE_W +: LANE_W] <= r_data;
      line_mask[ptr] <= 1'b1;
      ptr       <= ptr + IDX_W'(1);
      remaining <= remaining - IDX_W'(1);
      if (beat_err) line_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rresp_assembler.sv
// Directed bench for rresp_assembler.
// Each task drives one scenario and checks against hand-derived values.
module tb_rresp_assembler;

  localparam int LANE_W = 16;
  localparam int LANES  = 16;
  localparam int IDX_W  = 4;

  logic                    clk;
  logic                    rst;
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [IDX_W-1:0]        cmd_lane;
  logic [IDX_W-1:0]        cmd_len;
  logic                    cmd_merge;
  logic                    r_valid;
  logic                    r_ready;
  logic [LANE_W-1:0]       r_data;
  logic [1:0]              r_resp;
  logic                    r_last;
  logic                    line_valid;
  logic                    line_ready;
  logic [LANES*LANE_W-1:0] line_data;
  logic [LANES-1:0]        line_mask;
  logic                    line_err;

  int n_chk;
  int n_fail;
  logic [LANES*LANE_W-1:0] exp_d;

  rresp_assembler #(
    .LANE_W(LANE_W),
    .LANES (LANES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_lane  (cmd_lane),
    .cmd_len   (cmd_len),
    .cmd_merge (cmd_merge),
    .r_valid   (r_valid),
    .r_ready   (r_ready),
    .r_data    (r_data),
    .r_resp    (r_resp),
    .r_last    (r_last),
    .line_valid(line_valid),
    .line_ready(line_ready),
    .line_data (line_data),
    .line_mask (line_mask),
    .line_err  (line_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send_cmd(input logic [3:0] lane, input logic [3:0] len,
                          input logic merge);
    cmd_valid = 1'b1;
    cmd_lane  = lane;
    cmd_len   = len;
    cmd_merge = merge;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic beat(input logic [15:0] d, input logic [1:0] resp,
                      input logic last);
    r_valid = 1'b1;
    r_data  = d;
    r_resp  = resp;
    r_last  = last;
    @(posedge clk);
    #1;
    r_valid = 1'b0;
    r_resp  = 2'b00;
    r_last  = 1'b0;
  endtask

  task automatic consume();
    line_ready = 1'b1;
    @(posedge clk);
    #1;
    line_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_chk++;
    if ({cmd_ready, r_ready, line_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_hs got %b want 100", {cmd_ready, r_ready, line_valid});
    end
    n_chk++;
    if ({line_mask, line_err} !== 17'h0 || line_data !== '0) begin
      n_fail++;
      $display("FAIL reset_line mask %h err %b data %h want 0", line_mask, line_err, line_data);
    end
    beat(16'hDEAD, 2'b11, 1'b1);
    n_chk++;
    if (line_mask !== 16'h0 || line_data !== '0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_beat mask %h data %h rdy %b want 0/0/1", line_mask, line_data, cmd_ready);
    end
  endtask

  task automatic test_full_line();
    exp_d = '0;
    for (int k = 0; k < 16; k++) exp_d[k*16 +: 16] = 16'(k);
    send_cmd(4'd0, 4'd15, 1'b0);
    for (int i = 0; i < 16; i++) begin
      beat(16'(i), 2'b00, i == 15);
      if (i == 14) begin
        n_chk++;
        if (line_valid !== 1'b0 || r_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL full_mid valid %b ready %b want 0/1", line_valid, r_ready);
        end
      end
    end
    n_chk++;
    if ({cmd_ready, r_ready, line_valid} !== 3'b001) begin
      n_fail++;
      $display("FAIL full_hs got %b want 001", {cmd_ready, r_ready, line_valid});
    end
    n_chk++;
    if (line_data !== exp_d || line_mask !== 16'hFFFF || line_err !== 1'b0) begin
      n_fail++;
      $display("FAIL full_line data %h mask %h err %b", line_data, line_mask, line_err);
    end
    consume();
    n_chk++;
    if ({cmd_ready, line_valid} !== 2'b10 || line_data !== exp_d || line_mask !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL full_retain hs %b mask %h data %h", {cmd_ready, line_valid}, line_mask, line_data);
    end
  endtask

  task automatic test_wrap();
    exp_d = '0;
    exp_d[14*16 +: 16] = 16'hAAAA;
    exp_d[15*16 +: 16] = 16'hBBBB;
    exp_d[0*16  +: 16] = 16'hCCCC;
    exp_d[1*16  +: 16] = 16'hDDDD;
    send_cmd(4'd14, 4'd3, 1'b0);
    beat(16'hAAAA, 2'b00, 1'b0);
    beat(16'hBBBB, 2'b00, 1'b0);
    beat(16'hCCCC, 2'b00, 1'b0);
    beat(16'hDDDD, 2'b00, 1'b1);
    n_chk++;
    if (line_valid !== 1'b1 || line_data !== exp_d || line_mask !== 16'hC003 || line_err !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap v %b data %h mask %h err %b want mask c003", line_valid, line_data, line_mask, line_err);
    end
    consume();
  endtask

  task automatic test_merge();
    exp_d[2*16 +: 16] = 16'h5555;
    send_cmd(4'd2, 4'd0, 1'b1);
    beat(16'h5555, 2'b00, 1'b1);
    n_chk++;
    if (line_valid !== 1'b1 || line_data !== exp_d || line_mask !== 16'h0004 || line_err !== 1'b0) begin
      n_fail++;
      $display("FAIL merge v %b data %h mask %h err %b want mask 0004", line_valid, line_data, line_mask, line_err);
    end
    consume();
  endtask

  task automatic test_errors();
    exp_d = '0;
    exp_d[0*16 +: 16] = 16'h0101;
    exp_d[1*16 +: 16] = 16'h0202;
    send_cmd(4'd0, 4'd3, 1'b0);
    beat(16'h0101, 2'b00, 1'b0);
    beat(16'h0202, 2'b00, 1'b1);
    n_chk++;
    if (line_valid !== 1'b1 || line_data !== exp_d || line_mask !== 16'h0003 || line_err !== 1'b1) begin
      n_fail++;
      $display("FAIL early_last v %b data %h mask %h err %b want 1/0003/1", line_valid, line_data, line_mask, line_err);
    end
    consume();
    exp_d = '0;
    exp_d[4*16 +: 16] = 16'h4444;
    exp_d[5*16 +: 16] = 16'h5555;
    send_cmd(4'd4, 4'd1, 1'b0);
    beat(16'h4444, 2'b00, 1'b0);
    beat(16'h5555, 2'b00, 1'b0);
    n_chk++;
    if (line_valid !== 1'b1 || line_data !== exp_d || line_mask !== 16'h0030 || line_err !== 1'b1) begin
      n_fail++;
      $display("FAIL missing_last v %b data %h mask %h err %b want 1/0030/1", line_valid, line_data, line_mask, line_err);
    end
    consume();
    exp_d = '0;
    exp_d[7*16 +: 16] = 16'h7777;
    send_cmd(4'd7, 4'd0, 1'b0);
    beat(16'h7777, 2'b10, 1'b1);
    n_chk++;
    if (line_valid !== 1'b1 || line_data !== exp_d || line_mask !== 16'h0080 || line_err !== 1'b1) begin
      n_fail++;
      $display("FAIL resp_err v %b data %h mask %h err %b want 1/0080/1", line_valid, line_data, line_mask, line_err);
    end
    consume();
  endtask

  task automatic test_hold();
    exp_d = '0;
    exp_d[9*16 +: 16] = 16'h9999;
    send_cmd(4'd9, 4'd0, 1'b0);
    beat(16'h9999, 2'b00, 1'b1);
    cmd_valid = 1'b1;
    cmd_lane  = 4'd0;
    cmd_len   = 4'd0;
    cmd_merge = 1'b0;
    for (int c = 0; c < 5; c++) begin
      n_chk++;
      if ({cmd_ready, r_ready, line_valid} !== 3'b001 || line_data !== exp_d
          || line_mask !== 16'h0200 || line_err !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_%0d hs %b mask %h err %b data %h", c,
                 {cmd_ready, r_ready, line_valid}, line_mask, line_err, line_data);
      end
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    consume();
    n_chk++;
    if ({cmd_ready, line_valid} !== 2'b10 || line_mask !== 16'h0200 || line_data !== exp_d) begin
      n_fail++;
      $display("FAIL hold_release hs %b mask %h want 10/0200", {cmd_ready, line_valid}, line_mask);
    end
  endtask

  task automatic test_reset_mid();
    send_cmd(4'd0, 4'd3, 1'b0);
    beat(16'h0001, 2'b00, 1'b0);
    beat(16'h0002, 2'b00, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_chk++;
    if ({cmd_ready, r_ready, line_valid} !== 3'b100 || line_mask !== 16'h0
        || line_data !== '0 || line_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid hs %b mask %h err %b data %h",
               {cmd_ready, r_ready, line_valid}, line_mask, line_err, line_data);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      n_chk++;
      if (line_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid_pulse_%0d line_valid %b want 0", c, line_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_d = '0;
    exp_d[3*16 +: 16] = 16'h3333;
    send_cmd(4'd3, 4'd0, 1'b0);
    beat(16'h3333, 2'b00, 1'b1);
    consume();
    send_cmd(4'd4, 4'd0, 1'b1);
    exp_d[4*16 +: 16] = 16'h4321;
    beat(16'h4321, 2'b00, 1'b1);
    n_chk++;
    if (line_valid !== 1'b1 || line_data !== exp_d || line_mask !== 16'h0010 || line_err !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b v %b data %h mask %h err %b want 1/0010/0", line_valid, line_data, line_mask, line_err);
    end
    consume();
  endtask

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_lane   = '0;
    cmd_len    = '0;
    cmd_merge  = 1'b0;
    r_valid    = 1'b0;
    r_data     = '0;
    r_resp     = 2'b00;
    r_last     = 1'b0;
    line_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_full_line();
    test_wrap();
    test_merge();
    test_errors();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
